operand_fetch: RTL
==================

# operand_fetch

Register-read stage of the pipelined core, directly upstream of the ALU and the consumer of the register file's two read ports. Each accepted instruction drives the read addresses, gets forwarded operands from EX and MEM where a result is in flight, and captures them into the ID/EX pipeline register. Stalls and flushes are handled here: load-use interlock, EX back-pressure, and branch flush. Write-back needs no bypass: the register file writes on the falling edge, so its combinational read already returns the new value before the next rising edge.

## Interface
- XLEN, 32, datapath width.
- RA_W, 5, register address width; register 0 reads as zero and is never forwarded.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready.
- in_rs, in_rt  in  RA_W  source register numbers.
- in_uses_rs, in_uses_rt  in  1  source actually read; an unused source never stalls or forwards.
- in_rd  in  RA_W  destination register.
- in_reg_write, in_is_load  in  1  destination written; instruction is a load.
- in_imm  in  XLEN  sign-extended immediate, passed through.
- flush  in  1  kill ID/EX contents (taken branch).
- ex_hold  in  1  EX cannot accept; freeze ID/EX.
- rf_read_a1, rf_read_a2  out  RA_W  combinationally equal to in_rs, in_rt.
- rf_read_data1, rf_read_data2  in  XLEN  register file read data.
- ex_result  in  XLEN  combinational ALU result of the instruction held in ID/EX.
- mem_reg_write  in  1  instruction in MEM writes a register.
- mem_dest  in  RA_W  its destination.
- mem_result  in  XLEN  its final value; load data is included.
- out_valid, out_reg_write, out_is_load  out  1  ID/EX register.
- out_dest  out  RA_W; out_op_a, out_op_b, out_imm  out  XLEN  ID/EX register.

## Operation
- Operand select per source, in priority order:
  - address 0 → 0;
  - EX match (out_valid & out_reg_write & !out_is_load & out_dest==src) → ex_result;
  - MEM match (mem_reg_write & mem_dest==src) → mem_result;
  - otherwise register file data.
- EX beats MEM because it holds the newer value.
- Load-use hazard: out_valid & out_is_load & out_reg_write & out_dest!=0 & in_valid & ((in_uses_rs & in_rs==out_dest) | (in_uses_rt & in_rt==out_dest)).
- in_ready = !ex_hold & !hazard, or 1 whenever flush=1.
- Next-state priority:
  - rst: ID/EX cleared.
  - flush: bubble loaded; any incoming instruction is discarded, because decode is flushed in the same cycle.
  - ex_hold: ID/EX holds unchanged.
  - hazard: bubble loaded; decode holds its instruction and retries next cycle, then gets the load value from MEM.
  - in_valid: instruction captured with forwarded operands.
  - otherwise: bubble loaded.
- Bubble: out_valid, out_reg_write, out_is_load = 0; all data and address fields = 0.
- No arithmetic; all paths are full-width muxes.

## Timing
- Reset values: every out_* = 0. in_ready is 1 after reset unless ex_hold.
- Latency: one cycle from acceptance to out_valid.
- Load-use costs exactly one bubble cycle.
- Back-to-back dependent ALU instructions issue with no stall, via the EX forward.
- While ex_hold is asserted, the held operands do not re-sample forwarding sources.
- ex_hold and hazard together: hold wins; the hazard is re-evaluated when hold drops.
- flush together with ex_hold: flush wins, and the bubble is loaded.
- rst asserted mid-stall: ID/EX is cleared the next cycle and any pending hazard is gone.

## Structure
- Shared package: XLEN, RA_W, REG_ZERO constant, and the forwarding-select enum FWD_RF / FWD_EX / FWD_MEM.
- One sub-module, fwd_sel: address-compare logic plus a 3:1 mux, instantiated once per source.
- The hazard detect and ID/EX register sit in the top level.

## Test plan
- Writeback visibility: reg 5 = 7 in the register file, then accept `add` with rs=5 → out_op_a=7 one cycle later, in_ready=1 throughout.
- EX forward: `addi r3` producing ex_result=0x10, next instruction uses rs=3 → op_a=0x10, no stall.
- Load-use: `lw r4` in ID/EX, dependent instruction with rt=4 → in_ready=0 for one cycle and one bubble (out_valid=0). The retry then takes op_b from mem_result=0xABCD.
- Register 0: rs=0 with EX and MEM both writing dest 0 with value 0x55 → op_a=0.
- Priority and hold:
  - EX and MEM both target r2 (EX=1, MEM=2) → op_a=1.
  - ex_hold for 3 cycles → outputs stable and in_ready=0.
  - flush with ex_hold → out_valid=0 next cycle.
- Reset mid-stall: rst during a load-use stall → all outputs 0 next cycle, in_ready=1.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the register-read (operand fetch) stage.
// The ID/EX register layout and the forwarding-select encoding live here.
package operand_fetch_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam logic [RA_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_e;

  // ID/EX payload; the valid bit is carried separately beside it.
  typedef struct packed {
    logic            reg_write;
    logic            is_load;
    logic [RA_W-1:0] dest;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
  } idex_t;

endpackage

// File: rtl/operand_fetch_fwd_sel.sv
// Per-source operand select: register 0, EX forward, MEM forward or register file.
// EX is checked before MEM because it carries the younger result.
module operand_fetch_fwd_sel
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [RA_W-1:0]   src,
  input  logic              src_used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_en,
  input  logic [RA_W-1:0]   ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_fwd_en,
  input  logic [RA_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] operand
);

  fwd_e sel;

  // An unused source never forwards, so it simply shows the register file value.
  always_comb begin
    sel = FWD_RF;
    if (src_used && (src != REG_ZERO)) begin
      if (ex_fwd_en && (ex_dest == src)) begin
        sel = FWD_EX;
      end else if (mem_fwd_en && (mem_dest == src)) begin
        sel = FWD_MEM;
      end
    end
  end

  always_comb begin
    case (sel)
      FWD_EX:  operand = ex_result;
      FWD_MEM: operand = mem_result;
      default: operand = rf_data;
    endcase
    if (src == REG_ZERO) begin
      operand = '0;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives register file reads, forwards from EX/MEM,
// resolves load-use, EX back-pressure and branch flush, and holds ID/EX.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs,
  input  logic [RA_W-1:0] in_rt,
  input  logic            in_uses_rs,
  input  logic            in_uses_rt,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            in_is_load,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  input  logic            ex_hold,
  output logic [RA_W-1:0] rf_read_a1,
  output logic [RA_W-1:0] rf_read_a2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_dest,
  input  logic [XLEN-1:0] mem_result,
  output logic            out_valid,
  output logic            out_reg_write,
  output logic            out_is_load,
  output logic [RA_W-1:0] out_dest,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_imm
);

  logic            vld_p1;
  idex_t           idex_p1;
  idex_t           cap_p0;
  logic            ex_fwd_en;
  logic            hazard;
  logic [XLEN-1:0] op_a_p0;
  logic [XLEN-1:0] op_b_p0;

  assign rf_read_a1 = in_rs;
  assign rf_read_a2 = in_rt;

  // A load in ID/EX has no value yet, so it is excluded from the EX forward.
  assign ex_fwd_en = vld_p1 & idex_p1.reg_write & ~idex_p1.is_load;

  assign hazard = vld_p1 & idex_p1.is_load & idex_p1.reg_write &
                  (idex_p1.dest != REG_ZERO) & in_valid &
                  ((in_uses_rs & (in_rs == idex_p1.dest)) |
                   (in_uses_rt & (in_rt == idex_p1.dest)));

  assign in_ready = flush | (~ex_hold & ~hazard);

  operand_fetch_fwd_sel #(.DATA_W(XLEN)) u_fwd_a (
    .src        (in_rs),
    .src_used   (in_uses_rs),
    .rf_data    (rf_read_data1),
    .ex_fwd_en  (ex_fwd_en),
    .ex_dest    (idex_p1.dest),
    .ex_result  (ex_result),
    .mem_fwd_en (mem_reg_write),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .operand    (op_a_p0)
  );

  operand_fetch_fwd_sel #(.DATA_W(XLEN)) u_fwd_b (
    .src        (in_rt),
    .src_used   (in_uses_rt),
    .rf_data    (rf_read_data2),
    .ex_fwd_en  (ex_fwd_en),
    .ex_dest    (idex_p1.dest),
    .ex_result  (ex_result),
    .mem_fwd_en (mem_reg_write),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .operand    (op_b_p0)
  );

  always_comb begin
    cap_p0.reg_write = in_reg_write;
    cap_p0.is_load   = in_is_load;
    cap_p0.dest      = in_rd;
    cap_p0.op_a      = op_a_p0;
    cap_p0.op_b      = op_b_p0;
    cap_p0.imm       = in_imm;
  end

  // ---- stage boundary: decode/forward (p0) -> ID/EX register (p1) ----
  // Flush outranks hold; hold freezes ID/EX so held operands never re-sample.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1  <= 1'b0;
      idex_p1 <= '0;
    end else if (!ex_hold) begin
      if (in_valid && !hazard) begin
        vld_p1  <= 1'b1;
        idex_p1 <= cap_p0;
      end else begin
        vld_p1  <= 1'b0;
        idex_p1 <= '0;
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_reg_write = idex_p1.reg_write;
  assign out_is_load   = idex_p1.is_load;
  assign out_dest      = idex_p1.dest;
  assign out_op_a      = idex_p1.op_a;
  assign out_op_b      = idex_p1.op_b;
  assign out_imm       = idex_p1.imm;

endmodule
